apb_cmd_master: RTL and testbench



---
 rtl/apb_cmd_master.sv | 131 +++++++++++++
 tb/tb_apb_cmd_master.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
// APB requester: one valid/ready command becomes one SETUP->ACCESS transfer.
// Out-of-range addresses are rejected locally; hung transfers time out.
module apb_cmd_master #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int ADDR_LIMIT = 256,
    parameter int TIMEOUT    = 16
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int CNT_W = $clog2(TIMEOUT + 2);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W:0]  LIMIT    = (ADDR_W + 1)'(ADDR_LIMIT);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    // Bus strobes decode straight from the state so async reset drops them at once
    assign psel      = (state_q != IDLE);
    assign penable   = (state_q == ACCESS);
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign cmd_ready = (state_q == IDLE) && !rsp_valid_q && rst_n;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if ({1'b0, cmd_addr} < LIMIT) begin
                        pwrite_d = cmd_write;
                        paddr_d  = cmd_addr;
                        pwdata_d = cmd_wdata;
                        state_d  = SETUP;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : prdata;
                    rsp_err_d   = pslverr;
                    state_d     = IDLE;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    // pready still low at the end of the last allowed ACCESS cycle
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: directed cases plus random commands against a
// transaction-level model and a wait-state/error-programmable APB slave.
module tb_apb_cmd_master;

    localparam int TO    = 4;
    localparam int LIMIT = 256;

    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic        pready, pslverr;

    int          n_pass = 0;
    int          n_total = 0;

    int          sl_waits = 0;
    logic        sl_err = 1'b0;
    int          acc_cnt = 0;
    bit   [31:0] slv_mem [256];
    bit   [31:0] ref_mem [256];

    apb_cmd_master #(
        .ADDR_W(32), .DATA_W(32), .ADDR_LIMIT(LIMIT), .TIMEOUT(TO)
    ) dut (
        .pclk(pclk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    // Slave: completes after sl_waits wait states, commits writes only without error
    assign pready  = psel && penable && (acc_cnt == sl_waits);
    assign pslverr = sl_err;
    assign prdata  = sl_err ? 32'h0 : slv_mem[paddr[7:0]];

    always @(posedge pclk) begin
        if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
        if (psel && penable && pready && pwrite && !sl_err)
            slv_mem[paddr[7:0]] <= pwdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Transaction-level expectation: response, total latency, ACCESS length
    task automatic model(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input int waits, input logic serr,
                         output logic e, output logic [31:0] rd,
                         output int lat, output int pen);
        if (a >= LIMIT) begin
            e = 1'b1; rd = 32'h0; lat = 1; pen = 0;
        end else if (waits >= TO) begin
            e = 1'b1; rd = 32'h0; lat = TO + 2; pen = TO;
        end else begin
            e   = serr;
            pen = waits + 1;
            lat = waits + 3;
            rd  = (wr || serr) ? 32'h0 : ref_mem[a[7:0]];
            if (wr && !serr) ref_mem[a[7:0]] = d;
        end
    endtask

    task automatic run_cmd(input string tag, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input int waits, input logic serr,
                           input bit hold);
        logic        e_err;
        logic [31:0] e_rd;
        int          e_lat, e_pen, t, cyc, pen, first_psel, bad_bus, hold_bad;
        model(wr, a, d, waits, serr, e_err, e_rd, e_lat, e_pen);
        sl_waits = waits;
        sl_err   = serr;
        t = 0;
        while (!cmd_ready && t < 50) begin
            @(negedge pclk);
            t++;
        end
        check({tag, ".cmd_ready"}, {31'b0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        @(negedge pclk);
        cmd_valid = 1'b0;
        cyc = 1; pen = 0; first_psel = -1; bad_bus = 0;
        while (!rsp_valid && cyc < 60) begin
            if (penable) pen++;
            if (penable && !psel) bad_bus++;
            if (psel && first_psel < 0) first_psel = cyc;
            if (psel && (paddr !== a || pwrite !== wr || (wr && pwdata !== d))) bad_bus++;
            @(negedge pclk);
            cyc++;
        end
        check({tag, ".latency"}, cyc, e_lat);
        check({tag, ".access_cycles"}, pen, e_pen);
        check({tag, ".first_psel"}, first_psel, (a >= LIMIT) ? -1 : 1);
        check({tag, ".bus_stable"}, bad_bus, 0);
        check({tag, ".rsp_err"}, {31'b0, rsp_err}, {31'b0, e_err});
        check({tag, ".rsp_rdata"}, rsp_rdata, e_rd);
        check({tag, ".idle_after"}, {30'b0, psel, penable}, 32'd0);
        if (hold) begin
            hold_bad = 0;
            for (int i = 0; i < 4; i++) begin
                @(negedge pclk);
                if (!rsp_valid || cmd_ready || rsp_err !== e_err || rsp_rdata !== e_rd)
                    hold_bad++;
            end
            check({tag, ".rsp_hold"}, hold_bad, 0);
        end
        rsp_ready = 1'b1;
        @(negedge pclk);
        rsp_ready = 1'b0;
        check({tag, ".drained"}, {30'b0, rsp_valid, cmd_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        repeat (2) @(negedge pclk);
        check("reset.bus", {29'b0, psel, penable, pwrite}, 32'd0);
        check("reset.paddr", paddr, 32'd0);
        check("reset.pwdata", pwdata, 32'd0);
        check("reset.rsp", {30'b0, rsp_valid, rsp_err}, 32'd0);
        check("reset.rsp_rdata", rsp_rdata, 32'd0);
        check("reset.cmd_ready", {31'b0, cmd_ready}, 32'd0);
        rst_n = 1'b1;
        @(negedge pclk);

        run_cmd("wr_ff",  1'b1, 32'h0000_00ff, 32'hA5A5_A5A5, 0, 1'b0, 1'b0);
        run_cmd("rd_ff",  1'b0, 32'h0000_00ff, 32'h0, 2, 1'b0, 1'b0);
        run_cmd("rej100", 1'b1, 32'h0000_0100, 32'h1234_5678, 0, 1'b0, 1'b0);
        run_cmd("tmo",    1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 100, 1'b0, 1'b0);
        run_cmd("wr_0f",  1'b1, 32'h0000_000f, 32'hB545_A565, 0, 1'b0, 1'b1);
        run_cmd("wr_f0",  1'b1, 32'h0000_00f0, 32'h55B5_A5B5, 0, 1'b0, 1'b0);
        run_cmd("wr_f1",  1'b1, 32'h0000_00f1, 32'hCCCC_CCCC, 1, 1'b0, 1'b0);
        run_cmd("rd_0f",  1'b0, 32'h0000_000f, 32'h0, 0, 1'b0, 1'b0);
        run_cmd("rd_f0",  1'b0, 32'h0000_00f0, 32'h0, 0, 1'b0, 1'b0);
        run_cmd("rd_f1",  1'b0, 32'h0000_00f1, 32'h0, 3, 1'b0, 1'b0);
        run_cmd("rd_tmo", 1'b0, 32'h0000_0020, 32'h0, 0, 1'b0, 1'b0);
        run_cmd("slverr", 1'b1, 32'h0000_0030, 32'h1111_1111, 1, 1'b1, 1'b0);

        // Reset pulse in the middle of an ACCESS wait
        sl_waits = 100; sl_err = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'h7777_7777;
        @(negedge pclk);
        cmd_valid = 1'b0;
        @(negedge pclk);
        check("rst.in_access", {30'b0, psel, penable}, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("rst.bus_drop", {30'b0, psel, penable}, 32'd0);
        check("rst.rsp", {30'b0, rsp_valid, cmd_ready}, 32'd0);
        @(negedge pclk);
        rst_n = 1'b1;
        @(negedge pclk);
        check("rst.cmd_ready", {31'b0, cmd_ready}, 32'd1);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid || psel) bad++;
            @(negedge pclk);
        end
        check("rst.no_stale", bad, 0);
        run_cmd("rd_10", 1'b0, 32'h0000_0010, 32'h0, 0, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            logic        wr, serr;
            case ($urandom_range(0, 7))
                0:       a = 32'(LIMIT) + 32'($urandom_range(0, 255));
                1:       a = $urandom | 32'h8000_0000;
                default: a = 32'($urandom_range(0, 15));
            endcase
            wr   = ($urandom_range(0, 1) == 1);
            serr = ($urandom_range(0, 7) == 0);
            run_cmd("rand", wr, a, $urandom, $urandom_range(0, 5), serr,
                    $urandom_range(0, 3) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
